// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: recorder writes, replayer reads, one access in flight.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_req,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_wdata,
  output logic              rec_ack,
  input  logic              ply_req,
  input  logic [ADDR_W-1:0] ply_addr,
  output logic              ply_ack,
  output logic [DATA_W-1:0] ply_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_ply_q, last_ply_d;  // 1: replayer was granted most recently
  logic              mask_q, mask_d;          // first IDLE cycle after an ack
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rec_ack_q, rec_ack_d;
  logic              ply_ack_q, ply_ack_d;
  logic              disp_valid_q, disp_valid_d;
  logic              rec_eff, ply_eff, grant_rec, grant_ply;

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_ply_d   = last_ply_q;
    mask_d       = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rec_ack_d    = 1'b0;
    ply_ack_d    = 1'b0;
    disp_valid_d = 1'b0;
    grant_rec    = 1'b0;
    grant_ply    = 1'b0;
    // The requester acknowledged last cycle still has its req up; ignore it once.
    rec_eff = rec_req & ~(mask_q & ~last_ply_q);
    ply_eff = ply_req & ~(mask_q & last_ply_q);

    case (state_q)
      S_IDLE: begin
        if (rec_eff && ply_eff) begin
          grant_rec = last_ply_q;
          grant_ply = ~last_ply_q;
        end else begin
          grant_rec = rec_eff;
          grant_ply = ply_eff;
        end
        if (grant_rec) begin
          state_d      = S_WRITE;
          mem_wr_d     = 1'b1;
          mem_addr_d   = rec_addr;
          mem_wdata_d  = rec_wdata;
          rec_ack_d    = 1'b1;
          disp_valid_d = 1'b1;
          last_ply_d   = 1'b0;
        end else if (grant_ply) begin
          state_d    = S_READ;
          mem_rd_d   = 1'b1;
          mem_addr_d = ply_addr;
          last_ply_d = 1'b1;
          cnt_d      = '0;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        mask_d  = 1'b1;
      end
      S_READ: begin
        state_d      = S_WAIT;
        cnt_d        = CNT_W'(1);
        ply_ack_d    = (RD_LAT == 1);
        disp_valid_d = (RD_LAT == 1);
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_d = S_IDLE;
          mask_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          ply_ack_d    = (cnt_d == CNT_W'(RD_LAT));
          disp_valid_d = (cnt_d == CNT_W'(RD_LAT));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset leaves recorder winning the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_ply_q   <= 1'b1;
      mask_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rec_ack_q    <= 1'b0;
      ply_ack_q    <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_ply_q   <= last_ply_d;
      mask_q       <= mask_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rec_ack_q    <= rec_ack_d;
      ply_ack_q    <= ply_ack_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rec_ack    = rec_ack_q;
  assign ply_ack    = ply_ack_q;
  assign disp_valid = disp_valid_q;
  // Read data arrives in the ack cycle itself, so it is forwarded from the memory bus.
  assign ply_rdata  = ply_ack_q ? mem_rdata : '0;
  assign disp_data  = ply_ack_q ? mem_rdata : mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiter instances (RD_LAT=1 and RD_LAT=3) with behavioural memories.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rec_req   [2];
  logic [7:0] rec_addr  [2];
  logic [7:0] rec_wdata [2];
  logic       rec_ack   [2];
  logic       ply_req   [2];
  logic [7:0] ply_addr  [2];
  logic       ply_ack   [2];
  logic [7:0] ply_rdata [2];
  logic       mem_rd    [2];
  logic       mem_wr    [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic       disp_valid[2];
  logic [7:0] disp_data [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .rec_req(rec_req[0]), .rec_addr(rec_addr[0]), .rec_wdata(rec_wdata[0]), .rec_ack(rec_ack[0]),
    .ply_req(ply_req[0]), .ply_addr(ply_addr[0]), .ply_ack(ply_ack[0]), .ply_rdata(ply_rdata[0]),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .disp_valid(disp_valid[0]), .disp_data(disp_data[0])
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .rec_req(rec_req[1]), .rec_addr(rec_addr[1]), .rec_wdata(rec_wdata[1]), .rec_ack(rec_ack[1]),
    .ply_req(ply_req[1]), .ply_addr(ply_addr[1]), .ply_ack(ply_ack[1]), .ply_rdata(ply_rdata[1]),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .disp_valid(disp_valid[1]), .disp_data(disp_data[1])
  );

  // Memories: data valid exactly RD_LAT cycles after the mem_rd cycle, 0xEE otherwise.
  logic [7:0] mem   [2][256];
  logic [7:0] apipe [2][3];
  logic       vpipe [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
      apipe[d][0] <= mem_addr[d];
      vpipe[d][0] <= mem_rd[d];
      for (int k = 1; k < 3; k++) begin
        apipe[d][k] <= apipe[d][k-1];
        vpipe[d][k] <= vpipe[d][k-1];
      end
    end
  end

  always_comb begin
    mem_rdata[0] = vpipe[0][0] ? mem[0][apipe[0][0]] : 8'hEE;
    mem_rdata[1] = vpipe[1][2] ? mem[1][apipe[1][2]] : 8'hEE;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input int d, input string tag);
    check({tag, "_mem_rd"},     8'(mem_rd[d]),     8'h00);
    check({tag, "_mem_wr"},     8'(mem_wr[d]),     8'h00);
    check({tag, "_mem_addr"},   mem_addr[d],       8'h00);
    check({tag, "_mem_wdata"},  mem_wdata[d],      8'h00);
    check({tag, "_rec_ack"},    8'(rec_ack[d]),    8'h00);
    check({tag, "_ply_ack"},    8'(ply_ack[d]),    8'h00);
    check({tag, "_ply_rdata"},  ply_rdata[d],      8'h00);
    check({tag, "_disp_valid"}, 8'(disp_valid[d]), 8'h00);
    check({tag, "_disp_data"},  disp_data[d],      8'h00);
  endtask

  // Single write from an idle arbiter: strobe one cycle after the request is sampled.
  task automatic do_write(input int d, input logic [7:0] a, input logic [7:0] w);
    rec_req[d] = 1'b1; rec_addr[d] = a; rec_wdata[d] = w;
    tick();
    check("wr_mem_wr",     8'(mem_wr[d]),     8'h01);
    check("wr_mem_rd",     8'(mem_rd[d]),     8'h00);
    check("wr_mem_addr",   mem_addr[d],       a);
    check("wr_mem_wdata",  mem_wdata[d],      w);
    check("wr_rec_ack",    8'(rec_ack[d]),    8'h01);
    check("wr_disp_valid", 8'(disp_valid[d]), 8'h01);
    check("wr_disp_data",  disp_data[d],      w);
    rec_req[d] = 1'b0;
    tick();
    check("wr_ack_pulse",  8'(rec_ack[d]),    8'h00);
    check("wr_strobe_low", 8'(mem_wr[d]),     8'h00);
    check("wr_addr_hold",  mem_addr[d],       a);
    tick();
  endtask

  // Single read from an idle arbiter: ack lat+1 cycles after the request is sampled.
  task automatic do_read(input int d, input logic [7:0] a, input logic [7:0] exp, input int lat);
    ply_req[d] = 1'b1; ply_addr[d] = a;
    tick();
    check("rd_mem_rd",   8'(mem_rd[d]),  8'h01);
    check("rd_mem_wr",   8'(mem_wr[d]),  8'h00);
    check("rd_mem_addr", mem_addr[d],    a);
    check("rd_early_ack", 8'(ply_ack[d]), 8'h00);
    for (int k = 1; k < lat; k++) begin
      tick();
      check("rd_wait_noack", 8'(ply_ack[d]), 8'h00);
      check("rd_wait_rd",    8'(mem_rd[d]),  8'h00);
    end
    tick();
    check("rd_ply_ack",    8'(ply_ack[d]),    8'h01);
    check("rd_ply_rdata",  ply_rdata[d],      exp);
    check("rd_disp_valid", 8'(disp_valid[d]), 8'h01);
    check("rd_disp_data",  disp_data[d],      exp);
    ply_req[d] = 1'b0;
    tick();
    check("rd_ack_pulse",  8'(ply_ack[d]),    8'h00);
    check("rd_disp_pulse", 8'(disp_valid[d]), 8'h00);
    check("rd_addr_hold",  mem_addr[d],       a);
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rec_req[d] = 1'b0; rec_addr[d] = 8'h00; rec_wdata[d] = 8'h00;
      ply_req[d] = 1'b0; ply_addr[d] = 8'h00;
    end
    #1 rst_n = 1'b0;
    #2;
    check_all_zero(0, "rst1");
    check_all_zero(1, "rst3");
    tick();
    rst_n = 1'b1;

    // First grant on the first edge after release; single write.
    do_write(0, 8'h05, 8'h41);

    // Single read of a value just written, RD_LAT=1.
    do_write(0, 8'h05, 8'h5A);
    do_read(0, 8'h05, 8'h5A, 1);

    // Address extremes pass through unmodified.
    do_write(0, 8'h00, 8'h11);
    do_write(0, 8'hFF, 8'hEC);
    do_read(0, 8'h00, 8'h11, 1);
    do_read(0, 8'hFF, 8'hEC, 1);

    // Both requesting continuously after reset: W,idle,R,ack,idle repeating.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rec_req[0] = 1'b1; rec_addr[0] = 8'hFF; rec_wdata[0] = 8'h77;
    ply_req[0] = 1'b1; ply_addr[0] = 8'hFF;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rr_mem_wr",  8'(mem_wr[0]),  8'(i % 5 == 0));
      check("rr_rec_ack", 8'(rec_ack[0]), 8'(i % 5 == 0));
      check("rr_mem_rd",  8'(mem_rd[0]),  8'(i % 5 == 2));
      check("rr_ply_ack", 8'(ply_ack[0]), 8'(i % 5 == 3));
      check("rr_excl",    8'(mem_rd[0] & mem_wr[0]), 8'h00);
      if (i % 5 == 3) check("rr_rdata", ply_rdata[0], 8'h77);
    end
    rec_req[0] = 1'b0;
    ply_req[0] = 1'b0;
    tick();
    tick();

    // RD_LAT=3: write requested during WAIT is held off until after ack and IDLE.
    do_write(1, 8'h10, 8'hA5);
    ply_req[1] = 1'b1; ply_addr[1] = 8'h10;
    tick();
    check("hold_mem_rd", 8'(mem_rd[1]), 8'h01);
    rec_req[1] = 1'b1; rec_addr[1] = 8'h20; rec_wdata[1] = 8'h3C;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("hold_wait_wr",  8'(mem_wr[1]),  8'h00);
      check("hold_wait_ack", 8'(ply_ack[1]), 8'h00);
    end
    tick();
    check("hold_ply_ack", 8'(ply_ack[1]), 8'h01);
    check("hold_rdata",   ply_rdata[1],   8'hA5);
    check("hold_ack_wr",  8'(mem_wr[1]),  8'h00);
    ply_req[1] = 1'b0;
    tick();
    check("hold_idle_wr",  8'(mem_wr[1]),  8'h00);
    check("hold_idle_ack", 8'(rec_ack[1]), 8'h00);
    tick();
    check("hold_mem_wr",    8'(mem_wr[1]),  8'h01);
    check("hold_rec_ack",   8'(rec_ack[1]), 8'h01);
    check("hold_mem_addr",  mem_addr[1],    8'h20);
    check("hold_mem_wdata", mem_wdata[1],   8'h3C);
    rec_req[1] = 1'b0;
    tick();
    tick();
    do_read(1, 8'h20, 8'h3C, 3);

    // Reset during WAIT: outputs clear immediately, abandoned read never acks.
    ply_req[1] = 1'b1; ply_addr[1] = 8'h10;
    tick();
    tick();
    #2 rst_n = 1'b0;
    ply_req[1] = 1'b0;
    #1;
    check_all_zero(1, "rstwait");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rstwait_noack", 8'(ply_ack[1]), 8'h00);
      check("rstwait_nord",  8'(mem_rd[1]),  8'h00);
    end
    do_read(1, 8'h10, 8'hA5, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rec_req  input  1  recorder write request; held high until rec_ack.
REQ-007 rec_addr  input  ADDR_W  recorder write address; stable while rec_req high.
REQ-008 rec_wdata  input  DATA_W  recorder write data; stable while rec_req high.
REQ-009 rec_ack  output  1  one-cycle pulse: write performed this cycle.
REQ-010 ply_req  input  1  replayer read request; held high until ply_ack.
REQ-011 ply_addr  input  ADDR_W  replayer read address; stable while ply_req high.
REQ-012 ply_ack  output  1  one-cycle pulse: ply_rdata valid this cycle.
REQ-013 ply_rdata  output  DATA_W  read data, valid only while ply_ack high.
REQ-014 mem_rd / mem_wr  output  1 each  memory strobes, registered, mutually exclusive.
REQ-015 mem_addr  output  ADDR_W  memory address, registered.
REQ-016 mem_wdata  output  DATA_W  memory write data, registered.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after the mem_rd cycle.
REQ-018 disp_valid  output  1  one-cycle pulse to LED indicator on every completed access.
REQ-019 disp_data  output  DATA_W  written or read byte, valid while disp_valid high.

Function
REQ-020 FSM states IDLE, WRITE, READ, WAIT; exactly one access in flight at any time.
REQ-021 IDLE: sample requests at rising edge; winner decided per REQ-024..026; no request -> stay IDLE.
REQ-022 Recorder granted: next cycle state WRITE; mem_wr=1, mem_addr=rec_addr, mem_wdata=rec_wdata, rec_ack=1, disp_valid=1, disp_data=rec_wdata; following cycle IDLE.
REQ-023 Replayer granted: next cycle state READ; mem_rd=1, mem_addr=ply_addr; then WAIT for RD_LAT cycles counted from the READ cycle; on the cycle mem_rdata is valid: capture it, ply_ack=1, ply_rdata=mem_rdata, disp_valid=1, disp_data=mem_rdata; following cycle IDLE.
REQ-024 Only one requester high -> that requester wins.
REQ-025 Both high in same IDLE cycle -> round-robin: winner is requester NOT granted most recently; after reset recorder is treated as most-recent loser (recorder wins first tie).
REQ-026 On the first IDLE cycle after an ack, the just-acknowledged requester's req is masked; the other requester may be granted in that cycle.
REQ-027 Latency req-sampled to ack: write 1 cycle; read RD_LAT+1 cycles.
REQ-028 Requests arriving while not IDLE are held off; no loss, no reorder beyond REQ-025.
REQ-029 mem_addr/mem_wdata hold last values when strobes low; mem_rd and mem_wr never high together.
REQ-030 Requester dropping req before ack (protocol violation) while state IDLE -> no access; once granted, the access completes regardless.
REQ-031 Address wrap irrelevant to block: addresses passed through unmodified, full ADDR_W range legal including all-ones.

Reset
REQ-032 rst_n low -> immediately: state IDLE, all outputs 0, round-robin pointer = recorder-priority, WAIT counter 0.
REQ-033 Reset during READ or WAIT abandons the read; ply_ack not asserted for it after release.
REQ-034 First grant possible at first rising edge with rst_n high.

Verification
REQ-035 Single write: rec_req, addr 0x05, data 0x41 -> next cycle mem_wr=1, mem_addr=0x05, mem_wdata=0x41, rec_ack=1, disp_data=0x41; one pulse only.
REQ-036 Single read, RD_LAT=1, memory returns 0x5A at 0x05 -> mem_rd cycle, then ply_ack=1, ply_rdata=0x5A two cycles after req sampled.
REQ-037 Both req continuously after reset -> grant order W,R,W,R...; no back-to-back grants to the same requester; no cycle with both strobes.
REQ-038 RD_LAT=3, rec_req raised during WAIT -> write starts only after ply_ack cycle plus return to IDLE; write data intact.
REQ-039 rst_n low during WAIT -> all outputs 0 at once; after release no ply_ack; next ply_req served normally.
REQ-040 Addresses 0x00 and 0xFF read and written -> passed to mem_addr unmodified.
